// File: rtl/id_ex_ctrl.sv
// ID->EX pipeline register handshake and hazard control.
// Owns the E-stage valid bit, the payload enable and a one-load scoreboard.
module id_ex_ctrl #(
   parameter int RS_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             d_valid_i,
   output logic             E_ready_o,
   input  logic [RS_W-1:0]  d_rs1_i,
   input  logic [RS_W-1:0]  d_rs2_i,
   input  logic             d_rs1_use_i,
   input  logic             d_rs2_use_i,
   input  logic [RS_W-1:0]  d_rd_i,
   input  logic             d_wenReg_i,
   input  logic             d_renMem_i,
   output logic             E_valid_o,
   input  logic             e_ready_i,
   input  logic             flush_i,
   input  logic             ld_done_i,
   output logic             pipe_en_o,
   output logic             ld_pend_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic {S_EMPTY, S_FULL} e_st_t;
   typedef enum logic {LD_IDLE, LD_PEND} ld_st_t;

   e_st_t            e_st, e_nxt;
   ld_st_t           ld_st, ld_nxt;
   logic             e_ld;
   logic [RS_W-1:0]  e_rd;
   logic [RS_W-1:0]  ld_rd;
   logic             m1, m2, ld_block, hazard;
   logic             e_fire, ld_set, d_ld;

   assign E_valid_o = (e_st == S_FULL);
   assign ld_pend_o = (ld_st == LD_PEND);

   assign m1 = d_rs1_use_i & (d_rs1_i != '0) &
               ((E_valid_o & e_ld & (d_rs1_i == e_rd)) |
                (ld_pend_o & (d_rs1_i == ld_rd)));
   assign m2 = d_rs2_use_i & (d_rs2_i != '0) &
               ((E_valid_o & e_ld & (d_rs2_i == e_rd)) |
                (ld_pend_o & (d_rs2_i == ld_rd)));

   // Only one load may live in E or in the scoreboard at a time.
   assign ld_block = d_renMem_i & (ld_pend_o | (E_valid_o & e_ld));
   assign hazard   = d_valid_i & (m1 | m2 | ld_block);

   assign E_ready_o = ~hazard & ~flush_i & (~E_valid_o | e_ready_i);
   assign pipe_en_o = d_valid_i & E_ready_o;

   assign e_fire = E_valid_o & e_ready_i;
   assign ld_set = e_fire & e_ld & ~flush_i;
   assign d_ld   = d_renMem_i & d_wenReg_i & (d_rd_i != '0);

   always_comb begin
      e_nxt = e_st;
      if (flush_i)
         e_nxt = S_EMPTY;
      else if (pipe_en_o)
         e_nxt = S_FULL;
      else if (e_fire)
         e_nxt = S_EMPTY;
   end

   always_comb begin
      ld_nxt = ld_st;
      if (ld_set)
         ld_nxt = LD_PEND;
      else if (ld_done_i && ld_st == LD_PEND)
         ld_nxt = LD_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         e_st        <= S_EMPTY;
         ld_st       <= LD_IDLE;
         e_ld        <= 1'b0;
         e_rd        <= '0;
         ld_rd       <= '0;
         stall_cnt_o <= '0;
      end else begin
         e_st  <= e_nxt;
         ld_st <= ld_nxt;
         if (flush_i)
            e_ld <= 1'b0;
         else if (pipe_en_o) begin
            e_ld <= d_ld;
            e_rd <= d_rd_i;
         end
         if (ld_set)
            ld_rd <= e_rd;
         if (hazard && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Scoreboard bench for id_ex_ctrl: directed scenarios plus random traffic
// against an instruction-level reference model.
module tb_id_ex_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       d_valid_i;
   logic [4:0] d_rs1_i, d_rs2_i, d_rd_i;
   logic       d_rs1_use_i, d_rs2_use_i;
   logic       d_wenReg_i, d_renMem_i;
   logic       e_ready_i, flush_i, ld_done_i;

   logic        E_ready_o, E_valid_o, pipe_en_o, ld_pend_o;
   logic [15:0] stall_cnt_o;
   logic        E_ready_4, E_valid_4, pipe_en_4, ld_pend_4;
   logic [3:0]  stall_cnt_4;

   always #5 clk_i = ~clk_i;

   id_ex_ctrl #(.RS_W(5), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .d_valid_i(d_valid_i),
      .E_ready_o(E_ready_o), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
      .d_rs1_use_i(d_rs1_use_i), .d_rs2_use_i(d_rs2_use_i),
      .d_rd_i(d_rd_i), .d_wenReg_i(d_wenReg_i), .d_renMem_i(d_renMem_i),
      .E_valid_o(E_valid_o), .e_ready_i(e_ready_i), .flush_i(flush_i),
      .ld_done_i(ld_done_i), .pipe_en_o(pipe_en_o),
      .ld_pend_o(ld_pend_o), .stall_cnt_o(stall_cnt_o)
   );

   id_ex_ctrl #(.RS_W(5), .CNT_W(4)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i), .d_valid_i(d_valid_i),
      .E_ready_o(E_ready_4), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
      .d_rs1_use_i(d_rs1_use_i), .d_rs2_use_i(d_rs2_use_i),
      .d_rd_i(d_rd_i), .d_wenReg_i(d_wenReg_i), .d_renMem_i(d_renMem_i),
      .E_valid_o(E_valid_4), .e_ready_i(e_ready_i), .flush_i(flush_i),
      .ld_done_i(ld_done_i), .pipe_en_o(pipe_en_4),
      .ld_pend_o(ld_pend_4), .stall_cnt_o(stall_cnt_4)
   );

   typedef struct {
      bit       dv, u1, u2, wen, ren, er, fl, done, rst;
      bit [4:0] rs1, rs2, rd;
   } stim_t;

   typedef struct {
      bit dv_en; bit ld; bit [4:0] rd;
   } inst_t;

   typedef struct {
      bit rdy, pe, ev, lp;
      int cnt, cnt4;
   } exp_t;

   exp_t  sb[$];
   inst_t e_q[$];
   int    pend_q[$];
   int    m_cnt;
   int    n_chk = 0;
   int    n_pass = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      s.er = 1'b1;
      return s;
   endfunction

   function automatic stim_t alu(bit [4:0] a, bit [4:0] b, bit [4:0] d);
      stim_t s;
      s = idle();
      s.dv = 1; s.u1 = 1; s.u2 = 1; s.wen = 1;
      s.rs1 = a; s.rs2 = b; s.rd = d;
      return s;
   endfunction

   function automatic stim_t load(bit [4:0] a, bit [4:0] d);
      stim_t s;
      s = alu(a, 5'd0, d);
      s.u2 = 0; s.ren = 1;
      return s;
   endfunction

   function automatic bit dep(bit use_it, int rs);
      bit hit;
      hit = 0;
      if (use_it && rs != 0) begin
         if (e_q.size() != 0 && e_q[0].ld && e_q[0].rd == rs)
            hit = 1;
         if (pend_q.size() != 0 && pend_q[0] == rs)
            hit = 1;
      end
      return hit;
   endfunction

   task automatic cyc(input stim_t s);
      exp_t  x;
      inst_t ni;
      bit    hz, busy_ld, consumed;
      @(posedge clk_i);
      #1;
      d_valid_i = s.dv; d_rs1_i = s.rs1; d_rs2_i = s.rs2;
      d_rs1_use_i = s.u1; d_rs2_use_i = s.u2; d_rd_i = s.rd;
      d_wenReg_i = s.wen; d_renMem_i = s.ren; e_ready_i = s.er;
      flush_i = s.fl; ld_done_i = s.done; rst_i = s.rst;

      busy_ld = pend_q.size() != 0 || (e_q.size() != 0 && e_q[0].ld);
      hz = s.dv && (dep(s.u1, s.rs1) || dep(s.u2, s.rs2) ||
                    (s.ren && busy_ld));
      x.rdy  = !hz && !s.fl && (e_q.size() == 0 || s.er);
      x.pe   = s.dv && x.rdy;
      x.ev   = e_q.size() != 0;
      x.lp   = pend_q.size() != 0;
      x.cnt  = m_cnt;
      x.cnt4 = (m_cnt > 15) ? 15 : m_cnt;
      sb.push_back(x);

      if (s.rst) begin
         e_q.delete(); pend_q.delete(); m_cnt = 0;
      end else begin
         consumed = e_q.size() != 0 && s.er;
         if (consumed && e_q[0].ld && !s.fl) begin
            pend_q.delete(); pend_q.push_back(e_q[0].rd);
         end else if (s.done && pend_q.size() != 0)
            pend_q.delete();
         if (s.fl)
            e_q.delete();
         else if (x.pe) begin
            ni.dv_en = 1;
            ni.ld = s.ren && s.wen && s.rd != 0;
            ni.rd = s.rd;
            e_q.delete(); e_q.push_back(ni);
         end else if (consumed)
            e_q.delete();
         if (hz && m_cnt < 65535)
            m_cnt++;
      end
   endtask

   task automatic chk(string nm, int act, int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
   endtask

   always @(negedge clk_i) begin
      exp_t x;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         chk("E_ready", int'(E_ready_o), int'(x.rdy));
         chk("pipe_en", int'(pipe_en_o), int'(x.pe));
         chk("E_valid", int'(E_valid_o), int'(x.ev));
         chk("ld_pend", int'(ld_pend_o), int'(x.lp));
         chk("stall_cnt", int'(stall_cnt_o), x.cnt);
         chk("stall_cnt4", int'(stall_cnt_4), x.cnt4);
         chk("E_valid4", int'(E_valid_4), int'(x.ev));
         chk("pipe_en4", int'(pipe_en_4 & E_ready_4), int'(x.pe));
         chk("ld_pend4", int'(ld_pend_4), int'(x.lp));
      end
   end

   initial begin
      stim_t s;
      rst_i = 1; d_valid_i = 0; d_rs1_i = 0; d_rs2_i = 0; d_rd_i = 0;
      d_rs1_use_i = 0; d_rs2_use_i = 0; d_wenReg_i = 0; d_renMem_i = 0;
      e_ready_i = 0; flush_i = 0; ld_done_i = 0;
      repeat (2) @(posedge clk_i);
      m_cnt = 0;
      cyc(idle());

      for (int i = 0; i < 4; i++)
         cyc(alu(5'(i + 1), 5'(i + 2), 5'(i + 10)));
      for (int i = 0; i < 3; i++) begin
         s = alu(5'd1, 5'd2, 5'd3); s.er = 0; cyc(s);
      end
      cyc(alu(5'd1, 5'd2, 5'd3));
      cyc(load(5'd1, 5'd5));
      cyc(alu(5'd5, 5'd2, 5'd6));
      for (int i = 0; i < 4; i++)
         cyc(alu(5'd5, 5'd2, 5'd6));
      s = alu(5'd5, 5'd2, 5'd6); s.done = 1; cyc(s);
      cyc(alu(5'd5, 5'd2, 5'd6));
      cyc(load(5'd1, 5'd0));
      cyc(alu(5'd0, 5'd2, 5'd6));
      cyc(load(5'd1, 5'd7));
      s = alu(5'd1, 5'd7, 5'd6); s.u2 = 0; cyc(s);
      cyc(load(5'd1, 5'd8));
      cyc(load(5'd2, 5'd9));
      cyc(load(5'd2, 5'd9));
      s = load(5'd2, 5'd9); s.done = 1; cyc(s);
      cyc(alu(5'd1, 5'd2, 5'd3));
      s = alu(5'd1, 5'd2, 5'd3); s.done = 1; cyc(s);
      s = alu(5'd1, 5'd2, 5'd3); s.fl = 1; s.er = 0; cyc(s);
      cyc(idle());
      cyc(load(5'd1, 5'd4));
      for (int i = 0; i < 20; i++) begin
         s = load(5'd1, 5'd4); s.er = 0; cyc(s);
      end
      s = idle(); s.rst = 1; cyc(s);
      cyc(idle());

      for (int i = 0; i < 3000; i++) begin
         s.dv   = ($urandom_range(0, 9) < 8);
         s.rs1  = 5'($urandom_range(0, 3));
         s.rs2  = 5'($urandom_range(0, 3));
         s.rd   = 5'($urandom_range(0, 3));
         s.u1   = ($urandom_range(0, 3) != 0);
         s.u2   = ($urandom_range(0, 1) != 0);
         s.wen  = ($urandom_range(0, 4) != 0);
         s.ren  = ($urandom_range(0, 9) < 4);
         s.er   = ($urandom_range(0, 9) < 7);
         s.fl   = ($urandom_range(0, 19) == 0);
         s.done = ($urandom_range(0, 9) < 3);
         s.rst  = ($urandom_range(0, 199) == 0);
         cyc(s);
      end

      @(posedge clk_i);
      @(posedge clk_i);
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain left %0d expected 0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/id_ex_ctrl.md
# id_ex_ctrl

Handshake and hazard controller for the ID→EX pipeline register. It owns the E-stage valid bit and drives the payload latch enable for the ID/EX payload flops. It stalls decode on load-use and single-outstanding-load hazards, and kills the E stage on a redirect flush. It sits between the IDU's valid output and the EXU's ready input, and also keeps a saturating stall counter for performance bring-up.

## Interface
Parameters:
- RS_W, 5, register-index width
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- d_valid_i  in  1  IDU holds a decoded instruction
- E_ready_o  out  1  ID/EX can accept this cycle (to IDU)
- d_rs1_i, d_rs2_i  in  RS_W  source indices of the decoded instruction
- d_rs1_use_i, d_rs2_use_i  in  1  source actually read
- d_rd_i  in  RS_W  destination index
- d_wenReg_i  in  1  instruction writes the register file
- d_renMem_i  in  1  instruction is a load
- E_valid_o  out  1  E stage holds a live instruction (to EXU)
- e_ready_i  in  1  EXU consumes the E-stage instruction this cycle
- flush_i  in  1  redirect; kill the E stage and reject the ID instruction
- ld_done_i  in  1  outstanding load has written back
- pipe_en_o  out  1  load enable for all ID/EX payload flops
- ld_pend_o  out  1  a load is outstanding past EX
- stall_cnt_o  out  CNT_W  count of hazard-stall cycles

## Operation
- E-stage FSM has two states, S_EMPTY and S_FULL. E_valid_o = (state==S_FULL).
- Load scoreboard FSM has two states, LD_IDLE and LD_PEND, plus a register ld_rd[RS_W]. ld_pend_o = (state==LD_PEND).
- E-stage load tag registers e_ld and e_rd are captured when pipe_en_o fires. e_ld = d_renMem_i & d_wenReg_i & (d_rd_i!=0).
- match(x) = d_rsx_use_i & (d_rsx_i!=0) & ((E_valid_o & e_ld & d_rsx_i==e_rd) | (ld_pend_o & d_rsx_i==ld_rd)).
- hazard = d_valid_i & (match(1) | match(2) | (d_renMem_i & (ld_pend_o | (E_valid_o & e_ld)))). The last term enforces one load in E-or-pending at a time.
- E_ready_o = ~hazard & ~flush_i & (~E_valid_o | e_ready_i).
- pipe_en_o = d_valid_i & E_ready_o.
- Next E state, in priority order:
  - flush_i → S_EMPTY and e_ld←0.
  - pipe_en_o → S_FULL.
  - E_valid_o & e_ready_i → S_EMPTY.
  - Otherwise hold.
- Scoreboard:
  - Set when E_valid_o & e_ready_i & e_ld & ~flush_i: go to LD_PEND, ld_rd←e_rd.
  - Clear on ld_done_i while in LD_PEND.
  - Set wins over clear in the same cycle.
  - ld_done_i in LD_IDLE is ignored.
  - flush_i never clears LD_PEND, because that load has already left EX.
- stall_cnt_o increments by 1 each cycle hazard=1 and saturates at 2^CNT_W−1. It never wraps.
- Writes to x0 never create a hazard.

## Timing
- Reset values: S_EMPTY, LD_IDLE, e_ld=0, e_rd=0, ld_rd=0, stall_cnt_o=0.
- Consequently after reset E_valid_o=0, ld_pend_o=0, pipe_en_o=0.
- E_ready_o is 1 after reset unless a flush or hazard is present.
- Latency: an instruction accepted in cycle N shows E_valid_o=1 in N+1. Zero bubble for back-to-back instructions when e_ready_i=1.
- E_ready_o and pipe_en_o are combinational from state, d_*, e_ready_i and flush_i. There is no combinational path from d_valid_i to E_valid_o.
- E_valid_o stays high until e_ready_i=1 or flush_i=1. The payload is held stable meanwhile because pipe_en_o=0.
- flush_i in the same cycle as e_ready_i: the E instruction is treated as consumed but does not set the scoreboard; next state S_EMPTY.
- A load that leaves E in cycle N gives ld_pend_o=1 from N+1. ld_done_i in cycle M gives ld_pend_o=0 from M+1, so a dependent instruction can be accepted in M+1.
- rst_i asserted mid-stall or mid-load drops all state on the next edge; a pending ld_done_i is then ignored.

## Test plan
- Reset, then d_valid_i=1 for 4 cycles with independent sources and e_ready_i=1 → pipe_en_o=1 every cycle, E_valid_o=1 from cycle 2, stall_cnt_o=0.
- EXU backpressure: E_valid_o=1, e_ready_i=0 for 3 cycles → E_ready_o=0, pipe_en_o=0, E_valid_o stays 1; accept resumes in the cycle e_ready_i=1.
- Load-use: a load with rd=5 is in E, followed by an add with rs1=5 → add held until ld_done_i. ld_done_i pulses in cycle 10 → add accepted in cycle 11; stall_cnt_o equals the stalled cycle count.
- x0 and unused sources: load with rd=0, then a consumer with rs1=0; and a load with rd=7, then a consumer with rs2=7 but d_rs2_use_i=0 → no stall in either case.
- Two loads back-to-back → second load stalls until ld_done_i. Set and clear in the same cycle → LD_PEND with the new ld_rd.
- flush_i with E full and d_valid_i=1 → next cycle E_valid_o=0, ID instruction not accepted, ld_pend_o unchanged. Also saturation test: force CNT_W=4 and hold a hazard for 20 cycles → stall_cnt_o=15.
